// File: rtl/mic1_pkg.sv
// mic1_pkg: MIR field layout, selector encodings and core state shared by the MIC-1 stall core
package mic1_pkg;

  // Default register reset vectors (word addresses of the JVM memory areas)
  localparam logic [31:0] STACKPOINTER_ADDRESS       = 32'h0000_8000;
  localparam logic [31:0] LOCALVARIABLEFRAME_ADDRESS = 32'h0000_C000;
  localparam logic [31:0] CONSTANTPOOL_ADDRESS       = 32'h0000_4000;

  // MIR field offsets
  localparam int B_LO    = 0;
  localparam int M_LO    = 4;
  localparam int ALU_LO  = 16;
  localparam int SH_LO   = 22;
  localparam int J_JAMZ  = 24;
  localparam int J_JAMN  = 25;
  localparam int J_JMPC  = 26;
  localparam int NEXT_LO = 27;

  // C-bus destination bits inside the MIR
  localparam int C_MAR = 7;
  localparam int C_MDR = 8;
  localparam int C_PC  = 9;
  localparam int C_SP  = 10;
  localparam int C_LV  = 11;
  localparam int C_CPP = 12;
  localparam int C_TOS = 13;
  localparam int C_OPC = 14;
  localparam int C_H   = 15;

  // Memory-control bits inside the 3-bit mem field
  localparam int MB_FETCH = 0;
  localparam int MB_READ  = 1;
  localparam int MB_WRITE = 2;

  function automatic int mir_w(input int mpc_w);
    return 27 + mpc_w;
  endfunction

  function automatic int next_hi(input int mpc_w);
    return 26 + mpc_w;
  endfunction

  typedef enum logic [3:0] {
    B_MDR  = 4'd0,
    B_PC   = 4'd1,
    B_MBR  = 4'd2,
    B_MBRU = 4'd3,
    B_SP   = 4'd4,
    B_LV   = 4'd5,
    B_CPP  = 4'd6,
    B_TOS  = 4'd7,
    B_OPC  = 4'd8
  } b_sel_e;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// alu: MIC-1 ALU (AND / OR / NOT B / sum) with enable, invert and carry-in controls
module alu #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [5:0]   ctrl,
  output logic [W-1:0] y,
  output logic         n,
  output logic         z
);

  logic [W-1:0] ea;
  logic [W-1:0] eb;

  // ctrl = {F0, F1, ENA, ENB, INVA, INC}; INVA applies after ENA so "-1" is reachable
  always_comb begin
    ea = (ctrl[3] ? a : '0) ^ {W{ctrl[1]}};
    eb = ctrl[2] ? b : '0;
    y  = ctrl[5:4] == 2'b00 ? ea & eb :
         ctrl[5:4] == 2'b01 ? ea | eb :
         ctrl[5:4] == 2'b10 ? ~eb :
                              ea + eb + W'(ctrl[0]);
  end

  assign n = y[W-1];
  assign z = ~|y;

endmodule

// File: rtl/mic1_mem_ctrl.sv
// mic1_mem_ctrl: holds outstanding memory ops, retires each on its own ack, derives stall and err
module mic1_mem_ctrl
  import mic1_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       commit,
  input  logic [2:0] mem_bits,
  input  logic       mem_ack,
  input  logic       fetch_ack,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_fetch,
  output logic       stall,
  output logic       busy,
  output logic       rd_done,
  output logic       fetch_done,
  output logic       err
);

  logic [2:0] pnd;
  logic [2:0] issue;
  logic       data_busy;
  logic       illegal;

  assign illegal   = mem_bits[MB_READ] & mem_bits[MB_WRITE];
  assign issue     = {mem_bits[MB_WRITE], mem_bits[MB_READ] & ~illegal, mem_bits[MB_FETCH]};
  assign data_busy = pnd[MB_READ] | pnd[MB_WRITE];

  assign mem_read   = pnd[MB_READ];
  assign mem_write  = pnd[MB_WRITE];
  assign mem_fetch  = pnd[MB_FETCH];
  assign busy       = |pnd;
  assign rd_done    = pnd[MB_READ] & mem_ack;
  assign fetch_done = pnd[MB_FETCH] & fetch_ack;
  assign stall      = (data_busy & ~mem_ack) | (pnd[MB_FETCH] & ~fetch_ack);

  // A commit loads the new op set; otherwise each op drops out independently once acked
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pnd <= '0;
      err <= 1'b0;
    end else begin
      pnd <= commit ? issue : pnd & ~{mem_ack, mem_ack, fetch_ack};
      err <= err | (commit & illegal);
    end
  end

endmodule

// File: rtl/shifter.sv
// shifter: MIC-1 output shifter, ctrl = {SLL8, SRA1}
module shifter #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [1:0]   ctrl,
  output logic [W-1:0] y
);

  // SLL8 takes precedence if both bits are set
  always_comb begin
    y = ctrl[1] ? x << 8 : ctrl[0] ? {x[W-1], x[W-1:1]} : x;
  end

endmodule

// File: rtl/mic1_stall_core.sv
// mic1_stall_core: MIC-1 datapath and microsequencer with handshaked memory, halt and illegal-op flag
module mic1_stall_core
  import mic1_pkg::*;
#(
  parameter int                 DATA_W    = 32,
  parameter int                 MPC_W     = 9,
  parameter logic [DATA_W-1:0]  PC_RESET  = '1,
  parameter logic [DATA_W-1:0]  SP_RESET  = DATA_W'(STACKPOINTER_ADDRESS),
  parameter logic [DATA_W-1:0]  LV_RESET  = DATA_W'(LOCALVARIABLEFRAME_ADDRESS),
  parameter logic [DATA_W-1:0]  CPP_RESET = DATA_W'(CONSTANTPOOL_ADDRESS),
  parameter logic [MPC_W-1:0]   HALT_ADDR = '1
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [MPC_W-1:0]  mp_mem_addr,
  input  logic [26+MPC_W:0] mp_mem_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] mem_addr_instr,
  input  logic [7:0]        mem_rd_instr,
  output logic              mem_fetch,
  input  logic              fetch_ack,
  output logic              halted,
  output logic              err,
  output logic [DATA_W-1:0] out
);

  localparam int MIR_W = mir_w(MPC_W);

  logic [MIR_W-1:0]  mir;
  logic [MPC_W-1:0]  mpc;
  logic [MPC_W-1:0]  mpc_nxt;
  logic [MPC_W-1:0]  nxt;
  logic [DATA_W-1:0] mar, mdr, pc, sp, lv, cpp, tos, opc, h;
  logic [7:0]        mbr;
  logic [DATA_W-1:0] b_bus;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] c_bus;
  logic              alu_n, alu_z;
  logic              stall, busy, rd_done, fetch_done;
  logic              at_halt, halt_now, commit;
  state_e            state, state_nxt;

  assign mir = mp_mem_rdata;
  assign nxt = mir[next_hi(MPC_W):NEXT_LO];

  assign mp_mem_addr    = mpc;
  assign mem_addr       = mar;
  assign mem_wdata      = mdr;
  assign mem_addr_instr = pc;
  assign out            = h;
  assign halted         = state == HALT;

  // The halt microaddress never executes; the core waits there for outstanding ops, then stops
  assign at_halt  = mpc == HALT_ADDR;
  assign halt_now = at_halt & ~busy;
  assign commit   = (state != HALT) & ~stall & ~at_halt;

  // B-bus source select; unused encodings drive zero
  always_comb begin
    case (mir[B_LO +: 4])
      B_MDR:   b_bus = mdr;
      B_PC:    b_bus = pc;
      B_MBR:   b_bus = {{(DATA_W-8){mbr[7]}}, mbr};
      B_MBRU:  b_bus = {{(DATA_W-8){1'b0}}, mbr};
      B_SP:    b_bus = sp;
      B_LV:    b_bus = lv;
      B_CPP:   b_bus = cpp;
      B_TOS:   b_bus = tos;
      B_OPC:   b_bus = opc;
      default: b_bus = '0;
    endcase
  end

  alu #(.W(DATA_W)) u_alu (
    .a    (h),
    .b    (b_bus),
    .ctrl (mir[ALU_LO +: 6]),
    .y    (alu_y),
    .n    (alu_n),
    .z    (alu_z)
  );

  shifter #(.W(DATA_W)) u_shifter (
    .x    (alu_y),
    .ctrl (mir[SH_LO +: 2]),
    .y    (c_bus)
  );

  // JMPC ORs in the current MBR; JAMZ/JAMN only ever touch the top MPC bit
  assign mpc_nxt = mir[J_JMPC] ? nxt | MPC_W'(mbr) :
                   {nxt[MPC_W-1] | (mir[J_JAMZ] & alu_z) | (mir[J_JAMN] & alu_n), nxt[MPC_W-2:0]};

  mic1_mem_ctrl u_mem_ctrl (
    .clk        (clk),
    .resetn     (resetn),
    .commit     (commit),
    .mem_bits   (mir[M_LO +: 3]),
    .mem_ack    (mem_ack),
    .fetch_ack  (fetch_ack),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_fetch  (mem_fetch),
    .stall      (stall),
    .busy       (busy),
    .rd_done    (rd_done),
    .fetch_done (fetch_done),
    .err        (err)
  );

  // Sequencer state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= RUN;
    else state <= state_nxt;
  end

  // RUN issues, WAIT holds while ops are outstanding, HALT is terminal until reset
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     state_nxt = halt_now ? HALT : (commit && |mir[M_LO +: 3]) ? WAIT : RUN;
      WAIT:    state_nxt = stall ? WAIT : (commit && |mir[M_LO +: 3]) ? WAIT : RUN;
      default: state_nxt = HALT;
    endcase
  end

  // Architectural registers: C-bus loads on commit, read/fetch data land on their acks
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mpc <= '0;
      mar <= '0;
      mdr <= '0;
      mbr <= '0;
      pc  <= PC_RESET;
      sp  <= SP_RESET;
      lv  <= LV_RESET;
      cpp <= CPP_RESET;
      tos <= '0;
      opc <= '0;
      h   <= '0;
    end else begin
      if (commit) begin
        mpc <= mpc_nxt;
        if (mir[C_MAR]) mar <= c_bus;
        if (mir[C_PC])  pc  <= c_bus;
        if (mir[C_SP])  sp  <= c_bus;
        if (mir[C_LV])  lv  <= c_bus;
        if (mir[C_CPP]) cpp <= c_bus;
        if (mir[C_TOS]) tos <= c_bus;
        if (mir[C_OPC]) opc <= c_bus;
        if (mir[C_H])   h   <= c_bus;
      end
      if (rd_done) mdr <= mem_rdata;
      else if (commit && mir[C_MDR]) mdr <= c_bus;
      if (fetch_done) mbr <= mem_rd_instr;
    end
  end

endmodule

// File: tb/tb_mic1_stall_core.sv
// tb_mic1_stall_core: directed microprogram scenarios against the MIC-1 stall core
module tb_mic1_stall_core;

  localparam logic [5:0] A_B    = 6'h14;
  localparam logic [5:0] A_BP1  = 6'h35;
  localparam logic [5:0] A_ZERO = 6'h10;
  localparam logic [5:0] A_M1   = 6'h32;
  localparam logic [5:0] A_AP1  = 6'h39;
  localparam logic [8:0] W_MAR  = 9'h001;
  localparam logic [8:0] W_MDR  = 9'h002;
  localparam logic [8:0] W_PC   = 9'h004;
  localparam logic [8:0] W_H    = 9'h100;
  localparam logic [3:0] S_MDR  = 4'd0;
  localparam logic [3:0] S_PC   = 4'd1;
  localparam logic [3:0] S_MBR  = 4'd2;
  localparam logic [3:0] S_MBRU = 4'd3;
  localparam logic [3:0] S_SP   = 4'd4;
  localparam logic [3:0] S_LV   = 4'd5;
  localparam logic [3:0] S_CPP  = 4'd6;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [8:0]  mp_mem_addr;
  logic [35:0] mp_mem_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, mem_addr_instr, out;
  logic        mem_read, mem_write, mem_ack, mem_fetch, fetch_ack, halted, err;
  logic [7:0]  mem_rd_instr;
  logic [35:0] rom [512];
  int          vecs = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  assign mp_mem_rdata = rom[mp_mem_addr];

  mic1_stall_core #(
    .DATA_W(32), .MPC_W(9), .PC_RESET(32'hFFFF_FFFF), .SP_RESET(32'h0000_8000),
    .LV_RESET(32'h0000_C000), .CPP_RESET(32'h0000_4000), .HALT_ADDR(9'h1FF)
  ) dut (
    .clk(clk), .resetn(resetn), .mp_mem_addr(mp_mem_addr), .mp_mem_rdata(mp_mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_ack(mem_ack), .mem_addr_instr(mem_addr_instr),
    .mem_rd_instr(mem_rd_instr), .mem_fetch(mem_fetch), .fetch_ack(fetch_ack),
    .halted(halted), .err(err), .out(out)
  );

  // {next, jam{JMPC,JAMN,JAMZ}, shift{SLL8,SRA1}, alu, C, mem{wr,rd,fetch}, B}
  function automatic logic [35:0] mi(input logic [8:0] nx, input logic [2:0] j, input logic [1:0] sh,
                                      input logic [5:0] a, input logic [8:0] c, input logic [2:0] m,
                                      input logic [3:0] b);
    return {nx, j, sh, a, c, m, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    mem_ack = 1'b0;
    fetch_ack = 1'b0;
    mem_rdata = '0;
    mem_rd_instr = '0;
    for (int i = 0; i < 512; i++) rom[i] = '0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++; if (mp_mem_addr !== 9'h000) begin errs++; $display("FAIL reset_mpc: got %h want %h", mp_mem_addr, 9'h000); end
    vecs++; if (mem_addr_instr !== 32'hFFFF_FFFF) begin errs++; $display("FAIL reset_pc: got %h want %h", mem_addr_instr, 32'hFFFF_FFFF); end
    vecs++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL reset_mar: got %h want %h", mem_addr, 32'h0); end
    vecs++; if (mem_wdata !== 32'h0) begin errs++; $display("FAIL reset_mdr: got %h want %h", mem_wdata, 32'h0); end
    vecs++; if (out !== 32'h0) begin errs++; $display("FAIL reset_h: got %h want %h", out, 32'h0); end
    vecs++; if ({mem_read, mem_write, mem_fetch, halted, err} !== 5'b0) begin errs++; $display("FAIL reset_flags: got %b want %b", {mem_read, mem_write, mem_fetch, halted, err}, 5'b0); end
    rom[0] = mi(9'd1, 3'b000, 2'b00, A_B, W_H, 3'b000, S_SP);
    rom[1] = mi(9'd2, 3'b000, 2'b00, A_B, W_H, 3'b000, S_LV);
    rom[2] = mi(9'd3, 3'b000, 2'b00, A_B, W_H, 3'b000, S_CPP);
    rom[3] = mi(9'd4, 3'b000, 2'b10, A_B, W_H, 3'b000, S_SP);
    rom[4] = mi(9'd5, 3'b000, 2'b01, A_B, W_H, 3'b000, S_LV);
    rom[5] = mi(9'd5, 3'b000, 2'b00, A_ZERO, 9'h0, 3'b000, S_MDR);
    tick();
    vecs++; if (out !== 32'h0000_8000) begin errs++; $display("FAIL reset_sp: got %h want %h", out, 32'h0000_8000); end
    tick();
    vecs++; if (out !== 32'h0000_C000) begin errs++; $display("FAIL reset_lv: got %h want %h", out, 32'h0000_C000); end
    tick();
    vecs++; if (out !== 32'h0000_4000) begin errs++; $display("FAIL reset_cpp: got %h want %h", out, 32'h0000_4000); end
    tick();
    vecs++; if (out !== 32'h0080_0000) begin errs++; $display("FAIL shift_sll8: got %h want %h", out, 32'h0080_0000); end
    tick();
    vecs++; if (out !== 32'h0000_6000) begin errs++; $display("FAIL shift_sra1: got %h want %h", out, 32'h0000_6000); end
  endtask

  task automatic test_read_wait();
    do_reset();
    mem_rdata = 32'h0000_1234;
    rom[0] = mi(9'd1, 3'b000, 2'b00, A_B, W_MAR, 3'b010, S_SP);
    rom[1] = mi(9'd2, 3'b000, 2'b00, A_B, W_H, 3'b000, S_MDR);
    rom[2] = mi(9'd3, 3'b000, 2'b00, A_B, W_H, 3'b000, S_MDR);
    rom[3] = mi(9'd3, 3'b000, 2'b00, A_ZERO, 9'h0, 3'b000, S_MDR);
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++; if ({mem_read, mem_write, mem_fetch} !== 3'b100) begin errs++; $display("FAIL rd_req[%0d]: got %b want %b", i, {mem_read, mem_write, mem_fetch}, 3'b100); end
      vecs++; if (mem_addr !== 32'h0000_8000) begin errs++; $display("FAIL rd_addr[%0d]: got %h want %h", i, mem_addr, 32'h0000_8000); end
      vecs++; if (mp_mem_addr !== 9'h001) begin errs++; $display("FAIL rd_frozen_mpc[%0d]: got %h want %h", i, mp_mem_addr, 9'h001); end
    end
    vecs++; if (mem_wdata !== 32'h0) begin errs++; $display("FAIL rd_mdr_early: got %h want %h", mem_wdata, 32'h0); end
    mem_ack = 1'b1;
    vecs++; if (mem_read !== 1'b1) begin errs++; $display("FAIL rd_req_ack_cycle: got %b want %b", mem_read, 1'b1); end
    tick();
    mem_ack = 1'b0;
    vecs++; if (mem_wdata !== 32'h0000_1234) begin errs++; $display("FAIL rd_mdr: got %h want %h", mem_wdata, 32'h0000_1234); end
    vecs++; if (mp_mem_addr !== 9'h002) begin errs++; $display("FAIL rd_commit_mpc: got %h want %h", mp_mem_addr, 9'h002); end
    vecs++; if (mem_read !== 1'b0) begin errs++; $display("FAIL rd_drop: got %b want %b", mem_read, 1'b0); end
    vecs++; if (out !== 32'h0) begin errs++; $display("FAIL rd_h_old_mdr: got %h want %h", out, 32'h0); end
    tick();
    vecs++; if (out !== 32'h0000_1234) begin errs++; $display("FAIL rd_h_new_mdr: got %h want %h", out, 32'h0000_1234); end
  endtask

  task automatic test_fetch_jump();
    do_reset();
    fetch_ack = 1'b1;
    mem_rd_instr = 8'h10;
    rom[0] = mi(9'd1, 3'b000, 2'b00, A_ZERO, 9'h0, 3'b001, S_MDR);
    rom[1] = mi(9'd2, 3'b000, 2'b00, A_ZERO, 9'h0, 3'b000, S_MDR);
    rom[2] = mi(9'd0, 3'b100, 2'b00, A_BP1, W_PC, 3'b001, S_PC);
    rom[9'h10] = mi(9'h11, 3'b000, 2'b00, A_B, W_H, 3'b000, S_MBRU);
    rom[9'h11] = mi(9'h12, 3'b000, 2'b00, A_B, W_H, 3'b000, S_MBR);
    rom[9'h12] = mi(9'h12, 3'b000, 2'b00, A_B, W_H, 3'b000, S_MBRU);
    tick();
    vecs++; if (mem_fetch !== 1'b1) begin errs++; $display("FAIL fe_req: got %b want %b", mem_fetch, 1'b1); end
    vecs++; if (mem_addr_instr !== 32'hFFFF_FFFF) begin errs++; $display("FAIL fe_addr0: got %h want %h", mem_addr_instr, 32'hFFFF_FFFF); end
    tick();
    tick();
    mem_rd_instr = 8'hA5;
    vecs++; if (mem_addr_instr !== 32'h0) begin errs++; $display("FAIL fe_pc_wrap: got %h want %h", mem_addr_instr, 32'h0); end
    vecs++; if (mp_mem_addr !== 9'h010) begin errs++; $display("FAIL fe_jmpc: got %h want %h", mp_mem_addr, 9'h010); end
    vecs++; if (mem_fetch !== 1'b1) begin errs++; $display("FAIL fe_req2: got %b want %b", mem_fetch, 1'b1); end
    tick();
    vecs++; if (out !== 32'h0000_0010) begin errs++; $display("FAIL fe_mbr_old: got %h want %h", out, 32'h0000_0010); end
    vecs++; if (mem_fetch !== 1'b0) begin errs++; $display("FAIL fe_drop: got %b want %b", mem_fetch, 1'b0); end
    tick();
    vecs++; if (out !== 32'hFFFF_FFA5) begin errs++; $display("FAIL fe_mbr_sext: got %h want %h", out, 32'hFFFF_FFA5); end
    tick();
    vecs++; if (out !== 32'h0000_00A5) begin errs++; $display("FAIL fe_mbr_zext: got %h want %h", out, 32'h0000_00A5); end
  endtask

  task automatic test_split_ack();
    do_reset();
    mem_rdata = 32'h0000_55AA;
    mem_rd_instr = 8'h77;
    rom[0] = mi(9'd1, 3'b000, 2'b00, A_B, W_MAR, 3'b011, S_SP);
    rom[1] = mi(9'd2, 3'b000, 2'b00, A_B, W_H, 3'b000, S_MDR);
    rom[2] = mi(9'd2, 3'b000, 2'b00, A_B, W_H, 3'b000, S_MBRU);
    tick();
    vecs++; if ({mem_read, mem_fetch} !== 2'b11) begin errs++; $display("FAIL sp_req: got %b want %b", {mem_read, mem_fetch}, 2'b11); end
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    vecs++; if ({mem_read, mem_fetch} !== 2'b10) begin errs++; $display("FAIL sp_fetch_drop: got %b want %b", {mem_read, mem_fetch}, 2'b10); end
    vecs++; if (mp_mem_addr !== 9'h001) begin errs++; $display("FAIL sp_hold1: got %h want %h", mp_mem_addr, 9'h001); end
    tick();
    vecs++; if (mp_mem_addr !== 9'h001) begin errs++; $display("FAIL sp_hold2: got %h want %h", mp_mem_addr, 9'h001); end
    vecs++; if (mem_fetch !== 1'b0) begin errs++; $display("FAIL sp_fetch_stays_low: got %b want %b", mem_fetch, 1'b0); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    vecs++; if (mp_mem_addr !== 9'h002) begin errs++; $display("FAIL sp_commit: got %h want %h", mp_mem_addr, 9'h002); end
    vecs++; if (mem_wdata !== 32'h0000_55AA) begin errs++; $display("FAIL sp_mdr: got %h want %h", mem_wdata, 32'h0000_55AA); end
    vecs++; if (mem_read !== 1'b0) begin errs++; $display("FAIL sp_read_drop: got %b want %b", mem_read, 1'b0); end
    tick();
    vecs++; if (out !== 32'h0000_0077) begin errs++; $display("FAIL sp_mbr: got %h want %h", out, 32'h0000_0077); end
  endtask

  task automatic test_illegal();
    do_reset();
    mem_ack = 1'b1;
    fetch_ack = 1'b1;
    mem_rdata = 32'h0000_DEAD;
    rom[0] = mi(9'd1, 3'b000, 2'b00, A_B, W_MDR, 3'b111, S_SP);
    rom[1] = mi(9'd2, 3'b000, 2'b00, A_ZERO, 9'h0, 3'b000, S_MDR);
    rom[2] = mi(9'd2, 3'b000, 2'b00, A_ZERO, 9'h0, 3'b000, S_MDR);
    tick();
    vecs++; if ({mem_write, mem_read, mem_fetch} !== 3'b101) begin errs++; $display("FAIL il_req: got %b want %b", {mem_write, mem_read, mem_fetch}, 3'b101); end
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL il_err_set: got %b want %b", err, 1'b1); end
    vecs++; if (mem_wdata !== 32'h0000_8000) begin errs++; $display("FAIL il_wdata: got %h want %h", mem_wdata, 32'h0000_8000); end
    tick();
    vecs++; if (mem_wdata !== 32'h0000_8000) begin errs++; $display("FAIL il_no_read_load: got %h want %h", mem_wdata, 32'h0000_8000); end
    vecs++; if ({mem_write, mem_read, mem_fetch} !== 3'b000) begin errs++; $display("FAIL il_drop: got %b want %b", {mem_write, mem_read, mem_fetch}, 3'b000); end
    tick();
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL il_err_sticky: got %b want %b", err, 1'b1); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_ack = 1'b1;
    fetch_ack = 1'b1;
    rom[0] = mi(9'd1, 3'b000, 2'b00, A_B, W_MAR, 3'b010, S_SP);
    rom[1] = mi(9'd2, 3'b000, 2'b00, A_B, W_MAR, 3'b010, S_LV);
    rom[2] = mi(9'd3, 3'b000, 2'b00, A_B, W_H, 3'b000, S_MDR);
    rom[3] = mi(9'd4, 3'b000, 2'b00, A_B, W_H, 3'b000, S_MDR);
    rom[4] = mi(9'd4, 3'b000, 2'b00, A_ZERO, 9'h0, 3'b000, S_MDR);
    tick();
    mem_rdata = 32'h0000_0111;
    vecs++; if (mem_addr !== 32'h0000_8000) begin errs++; $display("FAIL bb_addr1: got %h want %h", mem_addr, 32'h0000_8000); end
    tick();
    mem_rdata = 32'h0000_0222;
    vecs++; if ({mem_read, mem_addr} !== {1'b1, 32'h0000_C000}) begin errs++; $display("FAIL bb_req2: got %b/%h want 1/%h", mem_read, mem_addr, 32'h0000_C000); end
    vecs++; if (mp_mem_addr !== 9'h002) begin errs++; $display("FAIL bb_nostall: got %h want %h", mp_mem_addr, 9'h002); end
    tick();
    vecs++; if (out !== 32'h0000_0111) begin errs++; $display("FAIL bb_data1: got %h want %h", out, 32'h0000_0111); end
    tick();
    vecs++; if (out !== 32'h0000_0222) begin errs++; $display("FAIL bb_data2: got %h want %h", out, 32'h0000_0222); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rom[0] = mi(9'd0, 3'b000, 2'b00, A_B, W_MAR, 3'b010, S_SP);
    tick();
    vecs++; if (mem_read !== 1'b1) begin errs++; $display("FAIL rm_req: got %b want %b", mem_read, 1'b1); end
    resetn = 1'b0;
    #1;
    vecs++; if ({mem_read, mem_addr} !== {1'b0, 32'h0}) begin errs++; $display("FAIL rm_async_drop: got %b/%h want 0/0", mem_read, mem_addr); end
    rom[0] = '0;
    mem_rdata = 32'h0000_0099;
    tick();
    resetn = 1'b1;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    vecs++; if (mem_wdata !== 32'h0) begin errs++; $display("FAIL rm_late_ack: got %h want %h", mem_wdata, 32'h0); end
  endtask

  task automatic test_jam_halt();
    do_reset();
    mem_ack = 1'b1;
    fetch_ack = 1'b1;
    rom[0]     = mi(9'h005, 3'b001, 2'b00, A_ZERO, W_H, 3'b000, S_MDR);
    rom[9'h105] = mi(9'h006, 3'b001, 2'b00, A_B, W_H, 3'b000, S_SP);
    rom[6]     = mi(9'h007, 3'b010, 2'b00, A_M1, W_H, 3'b000, S_MDR);
    rom[9'h107] = mi(9'h1FF, 3'b000, 2'b00, A_ZERO, 9'h0, 3'b000, S_MDR);
    rom[9'h1FF] = mi(9'h1FF, 3'b000, 2'b00, A_AP1, W_H, 3'b000, S_MDR);
    tick();
    vecs++; if (mp_mem_addr !== 9'h105) begin errs++; $display("FAIL jamz_taken: got %h want %h", mp_mem_addr, 9'h105); end
    tick();
    vecs++; if (mp_mem_addr !== 9'h006) begin errs++; $display("FAIL jamz_not_taken: got %h want %h", mp_mem_addr, 9'h006); end
    tick();
    vecs++; if ({mp_mem_addr, out} !== {9'h107, 32'hFFFF_FFFF}) begin errs++; $display("FAIL jamn_taken: got %h/%h want 107/ffffffff", mp_mem_addr, out); end
    tick();
    vecs++; if ({mp_mem_addr, halted} !== {9'h1FF, 1'b0}) begin errs++; $display("FAIL halt_arrive: got %h/%b want 1ff/0", mp_mem_addr, halted); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++; if (halted !== 1'b1) begin errs++; $display("FAIL halt_flag[%0d]: got %b want %b", i, halted, 1'b1); end
      vecs++; if ({mp_mem_addr, out} !== {9'h1FF, 32'hFFFF_FFFF}) begin errs++; $display("FAIL halt_frozen[%0d]: got %h/%h want 1ff/ffffffff", i, mp_mem_addr, out); end
    end
  endtask

  initial begin
    test_reset();
    test_read_wait();
    test_fetch_jump();
    test_split_ack();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_jam_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mic1_stall_core.md
Name: mic1_stall_core

Overview:
Parametrised next-generation MIC-1 microarchitecture core.
- Contains the MIR-driven datapath (H, MAR, MDR, PC, MBR, SP, LV, CPP, TOS, OPC) and the microsequencer.
- Data width, control-store depth and register reset vectors are set by parameters.
- Main memory uses a req/ack handshake with wait states, so memory latency is variable rather than fixed at one cycle.
- Adds a halt state and an illegal-microinstruction flag.
- Sits between the microprogram ROM and the main/instruction memory system.

Parameters:
DATA_W, 32, datapath and memory word width (>=16).
MPC_W, 9, microprogram address width; MIR width = 27+MPC_W.
PC_RESET, all ones, PC value after reset.
SP_RESET, `STACKPOINTER_ADDRESS, SP value after reset.
LV_RESET, `LOCALVARIABLEFRAME_ADDRESS, LV value after reset.
CPP_RESET, `CONSTANTPOOL_ADDRESS, CPP value after reset.
HALT_ADDR, 2**MPC_W-1, microaddress that halts the core.

Ports:
clk  in  1  clock; all state changes on posedge
resetn  in  1  reset, asynchronous, active-low
mp_mem_addr  out  MPC_W  control-store address (= MPC register)
mp_mem_rdata  in  27+MPC_W  MIR, combinational read of mp_mem_addr
mem_addr  out  DATA_W  word address (= MAR)
mem_wdata  out  DATA_W  write data (= MDR)
mem_rdata  in  DATA_W  read data, valid when mem_ack is high
mem_read  out  1  data read request
mem_write  out  1  data write request
mem_ack  in  1  completes the pending read/write this cycle
mem_addr_instr  out  DATA_W  byte address (= PC)
mem_rd_instr  in  8  fetch byte, valid when fetch_ack is high
mem_fetch  out  1  fetch request
fetch_ack  in  1  completes the pending fetch this cycle
halted  out  1  core stopped at HALT_ADDR
err  out  1  sticky: illegal memory-control encoding seen
out  out  DATA_W  H register, debug

Behaviour:
- Reset values:
  - MPC=0; MAR=MDR=MBR=TOS=OPC=H=0.
  - PC, SP, LV, CPP take their parameter values.
  - mem_read, mem_write, mem_fetch, halted and err are all 0.
  - The pending register is cleared.
  - Reset asserted mid-transaction drops the request immediately; an ack arriving after reset is ignored.
- MIR fields:
  - B_sel[3:0]; mem[6:4] = {write, read, fetch}; C_sel[15:7] = {H,OPC,TOS,CPP,LV,SP,PC,MDR,MAR}; ALU[21:16] = {F0,F1,ENA,ENB,INVA,INC}; shift[23:22]; jump[26:24] = {JMPC,JAMN,JAMZ}; next[26+MPC_W:27].
- Datapath is single-edge:
  - The B mux is combinational.
  - B_sel encodings: 0 MDR; 1 PC; 2 MBR sign-extended; 3 MBR zero-extended; 4 SP; 5 LV; 6 CPP; 7 TOS; 8 OPC; 9-15 drive 0.
  - The ALU A input is H. The existing alu and shifter are reused, widened to DATA_W.
- Commit: a cycle commits when it is not stalled and not halted. On commit:
  - every register selected in C_sel loads C;
  - pending <= mem bits of the current MIR;
  - MPC <= next-MPC.
- Next-MPC:
  - JMPC=1: next | zero-extended MBR (current register value).
  - Otherwise: next, with bit MPC_W-1 ORed with (JAMZ&Z)|(JAMN&N), where Z and N come from this cycle's ALU output.
- Memory timing: requests are asserted in the cycle after the issuing microinstruction. mem_read = pending.read, mem_write = pending.write, mem_fetch = pending.fetch, and the addresses are the already-updated MAR and PC.
- Stall: stall = (pending.read|pending.write)&!mem_ack | pending.fetch&!fetch_ack.
  - While stalled, no register, MPC or flag changes and the requests stay asserted and stable.
  - The read and fetch acks are tracked independently. An ack that arrives before its partner is latched, and the request is dropped the cycle after it is acked.
  - A pending op clears when its ack is seen.
- Loads:
  - A read ack loads MDR <= mem_rdata; this overrides a same-cycle C write to MDR.
  - A fetch ack loads MBR <= mem_rd_instr.
  - With 1-cycle memory (acks tied high) the timing equals classic MIC-1: data is usable two microinstructions after issue.
- Illegal encoding: read and write both set in one MIR.
  - err is set (sticky until reset) and the operation is executed as a write only.
  - A fetch in the same MIR is still honoured.
- Halt: when MPC==HALT_ADDR and no operation is pending, halted goes to 1 and the core freezes. Only reset exits halt.
- State machine: RUN, WAIT (pending not fully acked), HALT.
  - RUN->WAIT on commit with nonzero mem bits.
  - WAIT->RUN when all pending ops are acked.
  - RUN->HALT per the halt rule.
- Wrap: PC/MAR arithmetic wraps mod 2^DATA_W; MPC OR operations never exceed MPC_W bits.

Decomposition:
- mic1_pkg holds:
  - MIR field offsets as functions of MPC_W;
  - the B_sel enum;
  - C_sel bit indices;
  - the memory-control bit indices;
  - the state enum {RUN, WAIT, HALT}.
- One new sub-module, mic1_mem_ctrl, contains the pending/ack latching, stall generation, request outputs and err.
- alu and shifter are instantiated unchanged apart from the width parameter.

Test Plan:
- Reset with SP_RESET=0x8000: SP=0x8000, PC=0xFFFFFFFF, MPC=0, all requests 0, halted=0.
- MIR "MAR=SP; rd" with mem_ack delayed 3 cycles, mem_rdata=0x1234: mem_read high for 4 cycles with mem_addr=0x8000, MPC frozen; MDR=0x1234 after the ack; next microinstruction then commits.
- "PC=PC+1; fetch; goto(MBR)" with MBR=0x10, next=0x000, fetch_ack tied high: PC 0xFFFFFFFF->0, mem_addr_instr=0, MPC=0x010; MBR loads the fetched byte one cycle later.
- Read and fetch pending together, fetch_ack in cycle 1 and mem_ack in cycle 3: mem_fetch drops after cycle 1; commit occurs only in cycle 3.
- MIR with rd=wr=1: err=1, only mem_write asserted; err stays 1 through later microinstructions.
- JAMZ with ALU result 0 and next=0x05: MPC=0x105. Branch to HALT_ADDR: halted=1, no further register changes.
